fetch_queue: RTL

//  Decoupling instruction queue between the instruction fetcher and the decode stage.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 101 ++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the fetch-to-decode instruction queue.
//   fq_entry_t   : one buffered entry {pc, instr, misalign}
//   FQ_DEPTH     : default queue depth
//   select_instr : picks the 32-bit instruction half of a 64-bit fetch word
package fetch_pkg;

    localparam int FQ_DEPTH   = 4;
    localparam int FQ_ADDR_W  = 64;
    localparam int FQ_FETCH_W = 64;
    localparam int FQ_INSTR_W = 32;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        misalign;
    } fq_entry_t;

    // Address bit 2 selects which 32-bit half of the 8-byte fetch word holds the PC's instruction.
    function automatic logic [31:0] select_instr(input logic [63:0] word,
                                                 input logic [63:0] addr);
        return addr[2] ? word[63:32] : word[31:0];
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: decoupling FIFO between the instruction fetcher and decode.
// Each accepted fetch word is reduced to the instruction addressed by its PC and
// stored as {pc, instr, misalign}. A flush (or reset low) empties the queue in one cycle.
// Ports:
//   clk, reset (sync, active-low)
//   fetch_valid/fetch_ready/fetch_instr/fetch_addr : producer handshake
//   flush                                           : discard all entries
//   decode_valid/decode_ready/decode_instr/decode_pc/decode_misalign : consumer handshake
//   occupancy                                       : entries currently held (0..DEPTH)
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH   = FQ_DEPTH,
    parameter int ADDR_W  = FQ_ADDR_W,
    parameter int FETCH_W = FQ_FETCH_W,
    parameter int INSTR_W = FQ_INSTR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_valid,
    input  logic [FETCH_W-1:0]       fetch_instr,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic                     fetch_ready,
    input  logic                     flush,
    output logic                     decode_valid,
    input  logic                     decode_ready,
    output logic [INSTR_W-1:0]       decode_instr,
    output logic [ADDR_W-1:0]        decode_pc,
    output logic                     decode_misalign,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    fq_entry_t        mem [DEPTH];
    fq_entry_t        head;
    fq_entry_t        new_entry;

    assign rd_idx = rd_ptr[IDX_W-1:0];
    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign empty  = (rd_ptr == wr_ptr);
    assign full   = (rd_idx == wr_idx) && (rd_ptr[IDX_W] != wr_ptr[IDX_W]);

    // Ready depends only on the reset input and pointer state, never on decode_ready,
    // so a pop in a full cycle cannot open the door to a same-cycle push.
    assign fetch_ready  = reset && !full;
    assign decode_valid = !empty;

    assign push = fetch_valid && fetch_ready && !flush;
    assign pop  = decode_valid && decode_ready && !flush;

    assign new_entry.pc       = fetch_addr;
    assign new_entry.instr    = select_instr(fetch_instr, fetch_addr);
    assign new_entry.misalign = |fetch_addr[1:0];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage is never reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= new_entry;
        end
    end

    assign head = mem[rd_idx];

    // Outputs are forced to zero when empty so stale storage never leaks to decode.
    assign decode_instr    = empty ? '0 : head.instr;
    assign decode_pc       = empty ? '0 : head.pc;
    assign decode_misalign = empty ? 1'b0 : head.misalign;

    assign occupancy = wr_ptr - rd_ptr;

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset) !(push && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset) !(pop && empty));
    a_occ_range:    assert property (@(posedge clk) disable iff (!reset)
                                     occupancy <= PTR_W'(DEPTH));

endmodule
